digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised digit-serial adder/subtractor for the 32-bit adder family. One DIGIT-wide ripple slice computes a WIDTH-bit sum over WIDTH/DIGIT cycles, with a registered carry between digits. It trades latency for area against the fully parallel adders. It sits behind a valid/ready source and feeds a valid/ready sink, and it reports carry-out and signed overflow.

## Interface
- WIDTH, 32: operand and result width in bits.
- DIGIT, 4: bits processed per cycle. Must divide WIDTH and satisfy 1 ≤ DIGIT ≤ WIDTH. Elaboration fails otherwise.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0: compute a+b+cin. 1: compute a−b−cin.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In sub mode this is the inverse of borrow-out.
- ovf  out  1  signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- N = WIDTH/DIGIT.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready, latch a into opA and (sub ? ~b : b) into opB.
  - Set carry register to cin^sub, clear digit counter, go to RUN.
  - a, b, cin and sub are sampled only on this edge.
- RUN:
  - Each cycle, the slice adds the low DIGIT bits of opA and opB plus the carry.
  - opA and opB shift right by DIGIT.
  - The digit result enters the sum shift register at the top, which also shifts right by DIGIT.
  - The carry register takes the slice carry-out.
  - The counter increments.
  - On the cycle with counter = N−1, also register ovf = (carry into slice MSB) XOR (carry out of slice MSB), and go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable.
  - On out_valid&out_ready, go to IDLE.
  - in_valid is ignored in RUN and DONE.
- There is no same-cycle turnaround: in_ready rises the cycle after the output handshake.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full sum.
- With DIGIT=WIDTH, N=1 and RUN lasts one cycle.
- Reset asserted mid-operation aborts the operation. The state returns to IDLE immediately and the pending result is discarded, with no output handshake.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - All internal registers are 0.
- Acceptance edge is T. RUN occupies edges T+1..T+N. out_valid is high from just after edge T+N.
- Latency is N cycles from acceptance to out_valid.
- Minimum period between acceptances is N+2 cycles when out_ready is held high.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- Shared package adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a constant function num_digits(WIDTH, DIGIT);
  - the counter width, defined as $clog2(N) with a minimum of 1.
- Sub-module digit_adder #(DIGIT):
  - combinational DIGIT-bit ripple chain of full-adder cells;
  - outputs the digit sum, carry-out and the carry into its MSB (used for ovf).
- The top level holds the FSM, operand and sum shift registers, the carry register and the counter.

## Test plan
All scenarios use WIDTH=32, DIGIT=4 (N=8) unless stated otherwise.
- **Carry out:** a=0xFFFFFFFF, b=0x1, cin=0, sub=0. Expect sum=0x00000000, cout=1, ovf=0, out_valid exactly 8 cycles after acceptance, and in_ready=0 throughout.
- **Signed overflow:** a=0x7FFFFFFF, b=0x1, cin=0, sub=0. Expect sum=0x80000000, cout=0, ovf=1.
- **Subtract with borrow-in:** a=5, b=7, cin=1, sub=1. Expect sum=0xFFFFFFFD, cout=0 (borrow), ovf=0. Then a=7, b=5, cin=0, sub=1. Expect sum=2, cout=1.
- **Back-pressure:** out_ready low for 5 cycles in DONE while in_valid=1 with new operands. Expect sum, cout and ovf stable, in_ready=0, and the new operands not accepted. When out_ready rises, expect in_ready=1 on the next cycle.
- **Reset mid-operation:** rst_n low during the 3rd RUN cycle. Expect sum, cout, ovf, out_valid and busy =0 and in_ready=1 immediately, before the next clk edge. A fresh operation after release gives the correct result with no stale carry.
- **Parameter sweep:** random operands, cin and sub (≥1000 each) for (WIDTH, DIGIT) = (32,4), (32,1), (8,8), (16,2). Check against the behavioural model: sum = (a ± b ± cin) mod 2^WIDTH, cout as bit WIDTH, ovf from sign rules, and latency = WIDTH/DIGIT.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return (digit > 0) ? width / digit : 1;
  endfunction

  // Counter needs at least one bit even when a single digit covers the word.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = num_digits(width, digit);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple slice; also exposes the carry into its MSB
// so the caller can detect signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/sub: result valid WIDTH/DIGIT cycles after acceptance.
// Accepts only in IDLE; out_ready low parks the result in DONE indefinitely.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0) begin : g_bad_param
    $error("digit_serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             ovf_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic             last;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (op_a[DIGIT-1:0]),
    .b     (op_b[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New digits enter at the top so after N shifts the word is in place.
  if (DIGIT == WIDTH) begin : g_full
    assign sum_nxt = d_sum;
  end else begin : g_shift
    assign sum_nxt = {d_sum, sum_sr[WIDTH-1:DIGIT]};
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          sum_sr <= sum_nxt;
          carry  <= d_cout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            ovf_r <= d_cmsb ^ d_cout;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sr;
  assign cout      = carry;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed vectors and corner sequences on the
// default instance, then randomized sweeps over four parameter sets in parallel.
module tb_digit_serial_adder;

  logic clk;
  logic rst_n;

  logic [31:0] a_i [4];
  logic [31:0] b_i [4];
  logic        in_valid_i  [4];
  logic        cin_i       [4];
  logic        sub_i       [4];
  logic        out_ready_i [4];

  wire         in_ready_o  [4];
  wire         out_valid_o [4];
  wire         cout_o      [4];
  wire         ovf_o       [4];
  wire         busy_o      [4];
  wire  [31:0] sum_o       [4];
  wire  [7:0]  sum2;
  wire  [15:0] sum3;

  assign sum_o[2] = {24'd0, sum2};
  assign sum_o[3] = {16'd0, sum3};

  int n_checks = 0;
  int n_fail   = 0;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
    .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
    .out_valid(out_valid_o[0]), .out_ready(out_ready_i[0]), .sum(sum_o[0]),
    .cout(cout_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0]));

  digit_serial_adder #(.WIDTH(32), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
    .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]), .sub(sub_i[1]),
    .out_valid(out_valid_o[1]), .out_ready(out_ready_i[1]), .sum(sum_o[1]),
    .cout(cout_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]),
    .a(a_i[2][7:0]), .b(b_i[2][7:0]), .cin(cin_i[2]), .sub(sub_i[2]),
    .out_valid(out_valid_o[2]), .out_ready(out_ready_i[2]), .sum(sum2),
    .cout(cout_o[2]), .ovf(ovf_o[2]), .busy(busy_o[2]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i[3]), .in_ready(in_ready_o[3]),
    .a(a_i[3][15:0]), .b(b_i[3][15:0]), .cin(cin_i[3]), .sub(sub_i[3]),
    .out_valid(out_valid_o[3]), .out_ready(out_ready_i[3]), .sum(sum3),
    .cout(cout_o[3]), .ovf(ovf_o[3]), .busy(busy_o[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to WIDTH bits.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit ci, input bit sb,
                                output logic [31:0] s, output bit co, output bit ov);
    longint m, ua, ub, r, sa, sbv, sr;
    m   = (longint'(1) << w) - 1;
    ua  = longint'({32'd0, a}) & m;
    ub  = longint'({32'd0, b}) & m;
    r   = sb ? (ua - ub - longint'(ci)) : (ua + ub + longint'(ci));
    s   = 32'(r & m);
    co  = sb ? (r >= 0) : (r > m);
    sa  = a[w-1] ? ua - (m + 1) : ua;
    sbv = b[w-1] ? ub - (m + 1) : ub;
    sr  = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
    ov  = (sr > (m >> 1)) || (sr < -((m >> 1) + 1));
  endfunction

  task automatic run_op(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                        input bit ci, input bit sb, input logic [31:0] es,
                        input bit eco, input bit eov, input string tag);
    int  guard;
    int  lat;
    bit  run_ok;
    guard = 0;
    while (!in_ready_o[k] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    a_i[k] = a; b_i[k] = b; cin_i[k] = ci; sub_i[k] = sb;
    in_valid_i[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_i[k] = 1'b0;
    lat = 0;
    run_ok = 1'b1;
    while (!out_valid_o[k] && lat < n + 20) begin
      if (in_ready_o[k] !== 1'b0 || busy_o[k] !== 1'b1) run_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, n);
    chk({tag, " ready_low_in_run"}, run_ok, 1);
    chk({tag, " sum"}, sum_o[k], es);
    chk({tag, " cout"}, cout_o[k], eco);
    chk({tag, " ovf"}, ovf_o[k], eov);
    out_ready_i[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_i[k] = 1'b0;
    chk({tag, " ready_after_hs"}, in_ready_o[k], 1);
  endtask

  task automatic sweep(input int k, input int w, input int n, input int iters);
    logic [31:0] msk, ra, rb, es;
    bit          ci, sb, eco, eov;
    msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < iters; i++) begin
      ra = $urandom & msk;
      rb = $urandom & msk;
      // Bias some operands toward the sign/overflow boundaries.
      if ((i % 8) == 0) ra = msk >> 1;
      if ((i % 8) == 1) rb = ~(msk >> 1) & msk;
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      model(w, ra, rb, ci, sb, es, eco, eov);
      run_op(k, n, ra, rb, ci, sb, es, eco, eov, $sformatf("sweep%0d", k));
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          cin;
    bit          sub;
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int guard;
    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h5,         32'h7,         1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
    vecs[3] = '{32'h7,         32'h5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h0,         32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) begin
      a_i[k] = '0; b_i[k] = '0; in_valid_i[k] = 1'b0;
      cin_i[k] = 1'b0; sub_i[k] = 1'b0; out_ready_i[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready_o[0], 1);
    chk("reset out_valid", out_valid_o[0], 0);
    chk("reset busy", busy_o[0], 0);
    chk("reset sum", sum_o[0], 0);
    chk("reset cout", cout_o[0], 0);
    chk("reset ovf", ovf_o[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(0, 8, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

    // Back-pressure: result parked in DONE while new operands are offered.
    a_i[0] = 32'd3; b_i[0] = 32'd4; cin_i[0] = 1'b0; sub_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_i[0] = 1'b0;
    guard = 0;
    while (!out_valid_o[0] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp latency", guard, 8);
    a_i[0] = 32'd100; b_i[0] = 32'd200; sub_i[0] = 1'b1; in_valid_i[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp sum", sum_o[0], 32'd7);
      chk("bp cout", cout_o[0], 0);
      chk("bp ovf", ovf_o[0], 0);
      chk("bp in_ready", in_ready_o[0], 0);
      chk("bp out_valid", out_valid_o[0], 1);
    end
    out_ready_i[0] = 1'b1;
    in_valid_i[0] = 1'b0;
    @(posedge clk); #1;
    out_ready_i[0] = 1'b0;
    chk("bp ready_next", in_ready_o[0], 1);
    chk("bp valid_dropped", out_valid_o[0], 0);
    chk("bp sum_kept", sum_o[0], 32'd7);
    @(posedge clk); #1;
    chk("bp not_accepted", busy_o[0], 0);

    // Reset asserted in the third RUN cycle.
    a_i[0] = 32'hFFFF_FFFF; b_i[0] = 32'h1; cin_i[0] = 1'b1; sub_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst busy_before", busy_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst sum", sum_o[0], 0);
    chk("rst cout", cout_o[0], 0);
    chk("rst ovf", ovf_o[0], 0);
    chk("rst out_valid", out_valid_o[0], 0);
    chk("rst busy", busy_o[0], 0);
    chk("rst in_ready", in_ready_o[0], 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 8, 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, "post_rst");

    fork
      sweep(0, 32, 8, 1000);
      sweep(1, 32, 32, 1000);
      sweep(2, 8, 1, 1000);
      sweep(3, 16, 8, 1000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
